alu_rs: RTL and testbench

ALU reservation station: buffers up to `RS_SIZE` decoded integer ALU instructions from the dispatcher. Each entry waits until both of its source operands are available, either at dispatch or captured from the two common data buses (CDBs). The station then issues at most one ready instruction per cycle into the single-cycle ALU. It sits between decode/dispatch and the ALU and is the only driver of the ALU's input side.

---
 rtl/alu_rs_pkg.sv | 23 ++
 rtl/rs_prio_enc.sv | 23 ++
 rtl/alu_rs.sv | 186 ++++++++++++++++++
 tb/tb_alu_rs.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// Shared ALU opcode encodings and ROB tag width for the ALU reservation station and the ALU.
// Constants only; no logic, latency or flow control.
package alu_rs_pkg;

  localparam int ROB_SIZE_WIDTH = 4;

  typedef enum logic [2:0] {
    ALU_ADD_SUB = 3'd0,
    ALU_SLL     = 3'd1,
    ALU_SLT     = 3'd2,
    ALU_SLTU    = 3'd3,
    ALU_XOR     = 3'd4,
    ALU_SRL_SRA = 3'd5,
    ALU_OR      = 3'd6,
    ALU_AND     = 3'd7
  } alu_op_l1_e;

  localparam logic ALU_L2_ADD = 1'b0;
  localparam logic ALU_L2_SUB = 1'b1;
  localparam logic ALU_L2_SRL = 1'b0;
  localparam logic ALU_L2_SRA = 1'b1;

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index priority encoder: N request bits -> index of first set bit plus found flag.
// Purely combinational, zero latency, no backpressure.
module rs_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_in,
  output logic [IDX_W-1:0] idx_out,
  output logic             found_out
);

  always_comb begin
    idx_out   = '0;
    found_out = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_in[i]) begin
        idx_out   = i[IDX_W-1:0];
        found_out = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ALU ops until operands arrive via CDB, issues one per cycle.
// Issue is registered (ready at edge N -> alu_valid_out after N+1); dispatch is refused while full_out is high.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = ROB_SIZE_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             disp_valid_in,
  input  logic [2:0]       disp_op_L1_in,
  input  logic             disp_op_L2_in,
  input  logic [ROB_W-1:0] disp_rob_id_in,
  input  logic [31:0]      disp_vj_in,
  input  logic [31:0]      disp_vk_in,
  input  logic [ROB_W-1:0] disp_qj_in,
  input  logic [ROB_W-1:0] disp_qk_in,
  input  logic             disp_qj_pend_in,
  input  logic             disp_qk_pend_in,
  input  logic             cdb0_valid_in,
  input  logic [ROB_W-1:0] cdb0_rob_id_in,
  input  logic [31:0]      cdb0_value_in,
  input  logic             cdb1_valid_in,
  input  logic [ROB_W-1:0] cdb1_rob_id_in,
  input  logic [31:0]      cdb1_value_in,
  output logic             full_out,
  output logic             alu_valid_out,
  output logic [31:0]      alu_opr1_out,
  output logic [31:0]      alu_opr2_out,
  output logic [2:0]       alu_op_L1_out,
  output logic             alu_op_L2_out,
  output logic [ROB_W-1:0] alu_rob_id_out
);

  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] qj_pend_q, qj_pend_d;
  logic [RS_SIZE-1:0] qk_pend_q, qk_pend_d;
  logic [RS_SIZE-1:0] op_l2_q, op_l2_d;
  logic [2:0]         op_l1_q  [RS_SIZE];
  logic [2:0]         op_l1_d  [RS_SIZE];
  logic [31:0]        vj_q     [RS_SIZE];
  logic [31:0]        vj_d     [RS_SIZE];
  logic [31:0]        vk_q     [RS_SIZE];
  logic [31:0]        vk_d     [RS_SIZE];
  logic [ROB_W-1:0]   qj_q     [RS_SIZE];
  logic [ROB_W-1:0]   qj_d     [RS_SIZE];
  logic [ROB_W-1:0]   qk_q     [RS_SIZE];
  logic [ROB_W-1:0]   qk_d     [RS_SIZE];
  logic [ROB_W-1:0]   rob_id_q [RS_SIZE];
  logic [ROB_W-1:0]   rob_id_d [RS_SIZE];

  logic             alu_valid_q, alu_valid_d;
  logic [31:0]      alu_opr1_q, alu_opr1_d;
  logic [31:0]      alu_opr2_q, alu_opr2_d;
  logic [2:0]       alu_op_l1_q, alu_op_l1_d;
  logic             alu_op_l2_q, alu_op_l2_d;
  logic [ROB_W-1:0] alu_rob_id_q, alu_rob_id_d;

  logic [RS_SIZE-1:0] ready_req;
  logic [IDX_W-1:0]   free_idx, sel_idx;
  logic               free_found, sel_found;

  assign ready_req = busy_q & ~qj_pend_q & ~qk_pend_q;
  assign full_out  = &busy_q;

  rs_prio_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_enc (
    .req_in    (~busy_q),
    .idx_out   (free_idx),
    .found_out (free_found)
  );

  rs_prio_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_sel_enc (
    .req_in    (ready_req),
    .idx_out   (sel_idx),
    .found_out (sel_found)
  );

  // Returns {pend, value} after snooping both CDBs; cdb0 takes priority on a double hit.
  function automatic logic [32:0] snoop(input logic pend, input logic [ROB_W-1:0] tag,
                                        input logic [31:0] val);
    logic [32:0] res;
    res = {pend, val};
    if (pend && cdb0_valid_in && (cdb0_rob_id_in == tag)) begin
      res = {1'b0, cdb0_value_in};
    end else if (pend && cdb1_valid_in && (cdb1_rob_id_in == tag)) begin
      res = {1'b0, cdb1_value_in};
    end
    return res;
  endfunction

  always_comb begin
    busy_d       = busy_q;
    qj_pend_d    = qj_pend_q;
    qk_pend_d    = qk_pend_q;
    op_l2_d      = op_l2_q;
    op_l1_d      = op_l1_q;
    vj_d         = vj_q;
    vk_d         = vk_q;
    qj_d         = qj_q;
    qk_d         = qk_q;
    rob_id_d     = rob_id_q;
    alu_valid_d  = alu_valid_q;
    alu_opr1_d   = alu_opr1_q;
    alu_opr2_d   = alu_opr2_q;
    alu_op_l1_d  = alu_op_l1_q;
    alu_op_l2_d  = alu_op_l2_q;
    alu_rob_id_d = alu_rob_id_q;

    if (flush_in) begin
      busy_d      = '0;
      alu_valid_d = 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i]) begin
          {qj_pend_d[i], vj_d[i]} = snoop(qj_pend_q[i], qj_q[i], vj_q[i]);
          {qk_pend_d[i], vk_d[i]} = snoop(qk_pend_q[i], qk_q[i], vk_q[i]);
        end
      end

      // Selection uses registered pend bits, so a same-cycle wakeup issues one edge later.
      alu_valid_d = sel_found;
      if (sel_found) begin
        alu_opr1_d       = vj_q[sel_idx];
        alu_opr2_d       = vk_q[sel_idx];
        alu_op_l1_d      = op_l1_q[sel_idx];
        alu_op_l2_d      = op_l2_q[sel_idx];
        alu_rob_id_d     = rob_id_q[sel_idx];
        busy_d[sel_idx]  = 1'b0;
      end

      // free_idx comes from registered busy, so it never names the slot issuing now.
      if (disp_valid_in && !full_out && free_found) begin
        busy_d[free_idx]   = 1'b1;
        op_l1_d[free_idx]  = disp_op_L1_in;
        op_l2_d[free_idx]  = disp_op_L2_in;
        rob_id_d[free_idx] = disp_rob_id_in;
        qj_d[free_idx]     = disp_qj_in;
        qk_d[free_idx]     = disp_qk_in;
        {qj_pend_d[free_idx], vj_d[free_idx]} = snoop(disp_qj_pend_in, disp_qj_in, disp_vj_in);
        {qk_pend_d[free_idx], vk_d[free_idx]} = snoop(disp_qk_pend_in, disp_qk_in, disp_vk_in);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      busy_q       <= '0;
      alu_valid_q  <= 1'b0;
      alu_opr1_q   <= '0;
      alu_opr2_q   <= '0;
      alu_op_l1_q  <= '0;
      alu_op_l2_q  <= 1'b0;
      alu_rob_id_q <= '0;
    end else if (rdy_in) begin
      busy_q       <= busy_d;
      qj_pend_q    <= qj_pend_d;
      qk_pend_q    <= qk_pend_d;
      op_l2_q      <= op_l2_d;
      op_l1_q      <= op_l1_d;
      vj_q         <= vj_d;
      vk_q         <= vk_d;
      qj_q         <= qj_d;
      qk_q         <= qk_d;
      rob_id_q     <= rob_id_d;
      alu_valid_q  <= alu_valid_d;
      alu_opr1_q   <= alu_opr1_d;
      alu_opr2_q   <= alu_opr2_d;
      alu_op_l1_q  <= alu_op_l1_d;
      alu_op_l2_q  <= alu_op_l2_d;
      alu_rob_id_q <= alu_rob_id_d;
    end
  end

  assign alu_valid_out  = alu_valid_q;
  assign alu_opr1_out   = alu_opr1_q;
  assign alu_opr2_out   = alu_opr2_q;
  assign alu_op_L1_out  = alu_op_l1_q;
  assign alu_op_L2_out  = alu_op_l2_q;
  assign alu_rob_id_out = alu_rob_id_q;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios plus randomized traffic against a behavioural station model.
// Inputs change 1ns after the rising edge; outputs are compared at that same point.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int N  = 8;
  localparam int RW = ROB_SIZE_WIDTH;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, rdy, flush, disp_valid, disp_op2, qj_pend, qk_pend;
  logic [2:0]    disp_op1;
  logic [RW-1:0] disp_rob, disp_qj, disp_qk, cdb0_rob, cdb1_rob;
  logic [31:0]   disp_vj, disp_vk, cdb0_val, cdb1_val;
  logic          cdb0_valid, cdb1_valid;
  logic          full_out, alu_valid_out, alu_op_L2_out;
  logic [31:0]   alu_opr1_out, alu_opr2_out;
  logic [2:0]    alu_op_L1_out;
  logic [RW-1:0] alu_rob_id_out;

  alu_rs #(.RS_SIZE(N), .ROB_W(RW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush_in(flush),
    .disp_valid_in(disp_valid), .disp_op_L1_in(disp_op1), .disp_op_L2_in(disp_op2),
    .disp_rob_id_in(disp_rob), .disp_vj_in(disp_vj), .disp_vk_in(disp_vk),
    .disp_qj_in(disp_qj), .disp_qk_in(disp_qk),
    .disp_qj_pend_in(qj_pend), .disp_qk_pend_in(qk_pend),
    .cdb0_valid_in(cdb0_valid), .cdb0_rob_id_in(cdb0_rob), .cdb0_value_in(cdb0_val),
    .cdb1_valid_in(cdb1_valid), .cdb1_rob_id_in(cdb1_rob), .cdb1_value_in(cdb1_val),
    .full_out(full_out), .alu_valid_out(alu_valid_out),
    .alu_opr1_out(alu_opr1_out), .alu_opr2_out(alu_opr2_out),
    .alu_op_L1_out(alu_op_L1_out), .alu_op_L2_out(alu_op_L2_out),
    .alu_rob_id_out(alu_rob_id_out)
  );

  typedef struct packed {
    logic          busy;
    logic [2:0]    op1;
    logic          op2;
    logic [31:0]   vj, vk;
    logic [RW-1:0] qj, qk;
    logic          pj, pk;
    logic [RW-1:0] rob;
  } ent_t;

  ent_t          m [N];
  logic          mv = 1'b0;
  logic [31:0]   mo1 = '0, mo2 = '0;
  logic [2:0]    mop1 = '0;
  logic          mop2 = 1'b0;
  logic [RW-1:0] mrob = '0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_full();
    int cnt = 0;
    for (int i = 0; i < N; i++) cnt += int'(m[i].busy);
    return cnt == N;
  endfunction

  // An operand waiting on a tag takes the value of whichever bus carries it, cdb0 first.
  function automatic ent_t wake(input ent_t e);
    ent_t r = e;
    if (r.pj && cdb0_valid && cdb0_rob == r.qj) begin r.vj = cdb0_val; r.pj = 1'b0; end
    else if (r.pj && cdb1_valid && cdb1_rob == r.qj) begin r.vj = cdb1_val; r.pj = 1'b0; end
    if (r.pk && cdb0_valid && cdb0_rob == r.qk) begin r.vk = cdb0_val; r.pk = 1'b0; end
    else if (r.pk && cdb1_valid && cdb1_rob == r.qk) begin r.vk = cdb1_val; r.pk = 1'b0; end
    return r;
  endfunction

  task automatic model_edge();
    ent_t nx [N];
    int   sel = -1;
    int   fr  = -1;
    logic was_full;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m[i].busy = 1'b0;
      mv = 1'b0; mo1 = '0; mo2 = '0; mop1 = '0; mop2 = 1'b0; mrob = '0;
      return;
    end
    if (!rdy) return;
    if (flush) begin
      for (int i = 0; i < N; i++) m[i].busy = 1'b0;
      mv = 1'b0;
      return;
    end
    was_full = model_full();
    for (int i = 0; i < N; i++) begin
      if (sel < 0 && m[i].busy && !m[i].pj && !m[i].pk) sel = i;
      if (fr < 0 && !m[i].busy) fr = i;
      nx[i] = m[i].busy ? wake(m[i]) : m[i];
    end
    mv = (sel >= 0);
    if (sel >= 0) begin
      mo1 = m[sel].vj; mo2 = m[sel].vk; mop1 = m[sel].op1; mop2 = m[sel].op2; mrob = m[sel].rob;
      nx[sel].busy = 1'b0;
    end
    if (disp_valid && !was_full) begin
      nx[fr] = wake('{busy: 1'b1, op1: disp_op1, op2: disp_op2, vj: disp_vj, vk: disp_vk,
                      qj: disp_qj, qk: disp_qk, pj: qj_pend, pk: qk_pend, rob: disp_rob});
    end
    m = nx;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("alu_valid", 128'(alu_valid_out), 128'(mv));
    chk("alu_data", 128'({alu_opr1_out, alu_opr2_out, alu_op_L1_out, alu_op_L2_out, alu_rob_id_out}),
        128'({mo1, mo2, mop1, mop2, mrob}));
    chk("full", 128'(full_out), 128'(model_full()));
  endtask

  task automatic idle();
    rst_n = 1'b1; rdy = 1'b1; flush = 1'b0;
    disp_valid = 1'b0; disp_op1 = '0; disp_op2 = 1'b0; disp_rob = '0;
    disp_vj = '0; disp_vk = '0; disp_qj = '0; disp_qk = '0; qj_pend = 1'b0; qk_pend = 1'b0;
    cdb0_valid = 1'b0; cdb0_rob = '0; cdb0_val = '0;
    cdb1_valid = 1'b0; cdb1_rob = '0; cdb1_val = '0;
  endtask

  task automatic dispatch(input logic [2:0] op1, input logic op2, input logic [RW-1:0] rob,
                          input logic [31:0] vj, input logic [31:0] vk,
                          input logic [RW-1:0] qj, input logic pj);
    idle();
    disp_valid = 1'b1; disp_op1 = op1; disp_op2 = op2; disp_rob = rob;
    disp_vj = vj; disp_vk = vk; disp_qj = qj; qj_pend = pj;
  endtask

  initial begin
    for (int i = 0; i < N; i++) m[i] = '0;
    idle();
    rst_n = 1'b0;
    step();
    chk("reset_valid", 128'(alu_valid_out), 128'(0));
    chk("reset_full", 128'(full_out), 128'(0));
    chk("reset_opr1", 128'(alu_opr1_out), 128'(0));
    idle();
    step();

    // Ready ADD issues two edges after dispatch.
    dispatch(ALU_ADD_SUB, ALU_L2_ADD, 4'd3, 32'd5, 32'd7, 4'd0, 1'b0);
    step();
    chk("add_not_yet", 128'(alu_valid_out), 128'(0));
    idle();
    step();
    chk("add_valid", 128'(alu_valid_out), 128'(1));
    chk("add_opr", 128'({alu_opr1_out, alu_opr2_out}), 128'({32'd5, 32'd7}));
    chk("add_rob", 128'(alu_rob_id_out), 128'(3));

    // SUB waits for its producer, then wakes from cdb1.
    dispatch(ALU_ADD_SUB, ALU_L2_SUB, 4'd2, 32'd0, 32'd1, 4'd4, 1'b1);
    step();
    idle();
    for (int c = 0; c < 3; c++) begin
      step();
      chk("sub_wait", 128'(alu_valid_out), 128'(0));
    end
    cdb1_valid = 1'b1; cdb1_rob = 4'd4; cdb1_val = 32'h10;
    step();
    idle();
    step();
    chk("sub_issue", 128'({alu_valid_out, alu_opr1_out, alu_opr2_out, alu_op_L2_out}),
        128'({1'b1, 32'h10, 32'd1, 1'b1}));

    // Fill every slot waiting on tag 9; the ninth dispatch must be dropped.
    for (int i = 0; i < N; i++) begin
      dispatch(ALU_XOR, 1'b0, RW'(i), 32'(i * 3), 32'd100, 4'd9, 1'b1);
      step();
    end
    chk("fill_full", 128'(full_out), 128'(1));
    dispatch(ALU_OR, 1'b0, 4'd15, 32'd1, 32'd2, 4'd0, 1'b0);
    step();
    chk("drop_full", 128'(full_out), 128'(1));
    idle();
    cdb0_valid = 1'b1; cdb0_rob = 4'd9; cdb0_val = 32'h55;
    step();
    idle();
    for (int i = 0; i < N; i++) begin
      step();
      chk("drain_valid", 128'(alu_valid_out), 128'(1));
      chk("drain_order", 128'({alu_rob_id_out, alu_opr1_out}), 128'({RW'(i), 32'h55}));
      if (i == 0) chk("drain_full_fall", 128'(full_out), 128'(0));
    end
    step();
    chk("drain_done", 128'(alu_valid_out), 128'(0));

    // Dispatch bypass: pending tag broadcast in the same cycle.
    dispatch(ALU_SLL, 1'b0, 4'd1, 32'd0, 32'd2, 4'd6, 1'b1);
    cdb0_valid = 1'b1; cdb0_rob = 4'd6; cdb0_val = 32'hAB;
    step();
    idle();
    step();
    chk("bypass", 128'({alu_valid_out, alu_opr1_out}), 128'({1'b1, 32'hAB}));
    step();

    // Randomized traffic with occasional stalls, flushes and resets.
    for (int c = 0; c < 4000; c++) begin
      rst_n      = ($urandom_range(0, 199) != 0);
      rdy        = ($urandom_range(0, 7) != 0);
      flush      = ($urandom_range(0, 59) == 0);
      disp_valid = ($urandom_range(0, 3) != 0);
      disp_op1   = 3'($urandom_range(0, 7));
      disp_op2   = 1'($urandom_range(0, 1));
      disp_rob   = RW'($urandom_range(0, 15));
      disp_vj    = $urandom;
      disp_vk    = $urandom;
      disp_qj    = RW'($urandom_range(0, 15));
      disp_qk    = RW'($urandom_range(0, 15));
      qj_pend    = ($urandom_range(0, 2) == 0);
      qk_pend    = ($urandom_range(0, 2) == 0);
      cdb0_valid = ($urandom_range(0, 1) == 0);
      cdb0_rob   = RW'($urandom_range(0, 15));
      cdb0_val   = $urandom;
      cdb1_valid = ($urandom_range(0, 1) == 0);
      cdb1_rob   = RW'($urandom_range(0, 15));
      cdb1_val   = $urandom;
      if (cdb0_valid && cdb1_valid && cdb0_rob == cdb1_rob) cdb1_rob = cdb1_rob ^ RW'(1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
